// File: rtl/trade_summary.sv
// trade_summary: buffers parsed records, multiplies price x num with a
// serial shift-add unit, and emits one (date, total, count) summary per
// contiguous date group or on flush.
module trade_summary #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TOTAL_W    = 40,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_date [8],
    input  logic [7:0]         in_price [2],
    input  logic [7:0]         in_num [2],
    input  logic               flush,
    output logic               sum_valid,
    input  logic               sum_ready,
    output logic [7:0]         sum_date [8],
    output logic [TOTAL_W-1:0] sum_total,
    output logic [CNT_W-1:0]   sum_count,
    output logic               overflow
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned REC_W = 96;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;

    logic [2:0]         state, state_d;
    logic               after_emit, after_emit_d;
    logic               pop, flush_clr, mul_start, grp_open_set;
    logic               flush_pending;

    logic [REC_W-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full, wr_en;
    logic [63:0]        in_date_p;
    logic [REC_W-1:0]   in_rec, head;

    logic [REC_W-1:0]   hold;
    logic [63:0]        hold_date;
    logic [15:0]        hold_price, hold_num;

    logic               grp_open;
    logic [63:0]        grp_date;
    logic [TOTAL_W-1:0] grp_total;
    logic [CNT_W-1:0]   grp_count;
    logic [TOTAL_W:0]   acc_sum;

    logic [31:0]        product, mcand;
    logic [15:0]        mplier;
    logic [3:0]         iter;

    // Pack incoming record: date byte 0 is the most significant byte
    always_comb begin
        in_date_p = '0;
        for (int i = 0; i < 8; i++) begin
            in_date_p[63-8*i -: 8] = in_date[i];
        end
        in_rec = {in_date_p, in_price[0], in_price[1], in_num[0], in_num[1]};
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en      = in_valid && (!fifo_full || pop);
    assign head       = mem[rd_ptr[AW-1:0]];

    // Record FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_rec;
        end
    end

    // FIFO pointers and sticky drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (in_valid && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    // FSM state register; sum_valid registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            after_emit <= 1'b0;
            sum_valid  <= 1'b0;
        end else begin
            state      <= state_d;
            after_emit <= after_emit_d;
            sum_valid  <= (state_d == S_EMIT);
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d      = state;
        after_emit_d = after_emit;
        pop          = 1'b0;
        flush_clr    = 1'b0;
        mul_start    = 1'b0;
        grp_open_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_CHECK;
                end else if (flush_pending) begin
                    if (grp_open) begin
                        state_d      = S_EMIT;
                        after_emit_d = 1'b0;
                    end else begin
                        flush_clr = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (grp_open && (hold_date != grp_date)) begin
                    state_d      = S_EMIT;
                    after_emit_d = 1'b1;
                end else begin
                    state_d      = S_MUL;
                    mul_start    = 1'b1;
                    grp_open_set = !grp_open;
                end
            end
            S_MUL: begin
                if (iter == 4'd15) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                state_d = S_IDLE;
            end
            S_EMIT: begin
                if (sum_ready) begin
                    if (after_emit) begin
                        state_d      = S_MUL;
                        mul_start    = 1'b1;
                        grp_open_set = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        flush_clr = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Flush request latch; a clear takes priority over a coincident pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pending <= 1'b0;
        end else if (flush_clr) begin
            flush_pending <= 1'b0;
        end else if (flush) begin
            flush_pending <= 1'b1;
        end
    end

    // Held record popped from the FIFO head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (pop) begin
            hold <= head;
        end
    end

    assign hold_date  = hold[95:32];
    assign hold_price = hold[31:16];
    assign hold_num   = hold[15:0];

    // Serial shift-add multiplier, price bits consumed LSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            iter    <= '0;
        end else if (mul_start) begin
            product <= '0;
            mcand   <= 32'(hold_num);
            mplier  <= hold_price;
            iter    <= '0;
        end else if (state == S_MUL) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= {mcand[30:0], 1'b0};
            mplier <= {1'b0, mplier[15:1]};
            iter   <= iter + 4'd1;
        end
    end

    assign acc_sum = {1'b0, grp_total} + (TOTAL_W+1)'(product);

    // Group accumulator: open, saturating accumulate, close on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_open  <= 1'b0;
            grp_date  <= '0;
            grp_total <= '0;
            grp_count <= '0;
        end else if (grp_open_set) begin
            grp_open  <= 1'b1;
            grp_date  <= hold_date;
            grp_total <= '0;
            grp_count <= '0;
        end else if (state == S_EMIT && sum_ready) begin
            grp_open <= 1'b0;
        end else if (state == S_ACC) begin
            grp_total <= acc_sum[TOTAL_W] ? '1 : acc_sum[TOTAL_W-1:0];
            if (grp_count != '1) begin
                grp_count <= grp_count + CNT_W'(1);
            end
        end
    end

    // Summary payload comes straight from the group registers
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sum_date[i] = grp_date[63-8*i -: 8];
        end
    end

    assign sum_total = grp_total;
    assign sum_count = grp_count;

endmodule

// File: tb/tb_trade_summary.sv
// Scoreboard bench for trade_summary: stimulus pushes expected summaries,
// a negedge monitor pops and compares each accepted summary.
module tb_trade_summary;

    localparam int unsigned TW = 32;
    localparam int unsigned CW = 16;

    localparam logic [63:0] D11 = 64'h1111111111111111;
    localparam logic [63:0] D22 = 64'h2222222222222222;
    localparam logic [63:0] D33 = 64'h3333333333333333;
    localparam logic [63:0] D44 = 64'h4444444444444444;
    localparam logic [63:0] D55 = 64'h5555555555555555;
    localparam logic [63:0] D66 = 64'h6666666666666666;
    localparam logic [63:0] D77 = 64'h7777777777777777;
    localparam logic [63:0] D88 = 64'h8888888888888888;

    typedef struct packed {
        logic [63:0]   date;
        logic [TW-1:0] total;
        logic [CW-1:0] count;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_date [8];
    logic [7:0]    in_price [2];
    logic [7:0]    in_num [2];
    logic          flush;
    logic          sum_valid;
    logic          sum_ready;
    logic [7:0]    sum_date [8];
    logic [TW-1:0] sum_total;
    logic [CW-1:0] sum_count;
    logic          overflow;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    trade_summary #(.FIFO_DEPTH(4), .TOTAL_W(TW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_date(in_date),
        .in_price(in_price), .in_num(in_num), .flush(flush),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_date(sum_date),
        .sum_total(sum_total), .sum_count(sum_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] date_p();
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[63-8*i -: 8] = sum_date[i];
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [15:0] p, input logic [15:0] n);
        for (int i = 0; i < 8; i++) in_date[i] = d[63-8*i -: 8];
        in_price[0] = p[15:8];
        in_price[1] = p[7:0];
        in_num[0]   = n[15:8];
        in_num[1]   = n[7:0];
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [TW-1:0] t, input logic [CW-1:0] c);
        exp_t e;
        e.date  = d;
        e.total = t;
        e.count = c;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        cycles(3);
    endtask

    // Monitor: compare every summary the consumer accepts
    always @(negedge clk) begin
        if (!rst && sum_valid && sum_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_summary date=%h total=%h count=%h",
                         date_p(), sum_total, sum_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum_date", date_p(), e.date);
                check("sum_total", 64'(sum_total), 64'(e.total));
                check("sum_count", 64'(sum_count), 64'(e.count));
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; sum_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_date[i] = 8'h00;
        in_price[0] = 8'h00; in_price[1] = 8'h00;
        in_num[0] = 8'h00; in_num[1] = 8'h00;
        cycles(3);
        check("rst_sum_valid", 64'(sum_valid), 64'd0);
        check("rst_sum_date", date_p(), 64'd0);
        check("rst_sum_total", 64'(sum_total), 64'd0);
        check("rst_sum_count", 64'(sum_count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        cycles(2);

        // Single record then flush; summary appears two cycles after flush
        send(D11, 16'h1234, 16'h0010);
        cycles(25);
        push(D11, 32'h12340, 16'd1);
        pulse_flush();
        check("flush_lat_0", 64'(sum_valid), 64'd0);
        cycles(1);
        check("flush_lat_1", 64'(sum_valid), 64'd1);
        drain("drain_single", 20);

        // Same date twice, then a date change closes the group at CHECK
        send(D11, 16'h1234, 16'h0010);
        send(D11, 16'h1234, 16'h0010);
        cycles(45);
        push(D11, 32'h24680, 16'd2);
        send(D22, 16'h0002, 16'h0003);
        cycles(1);
        check("chg_lat_e1", 64'(sum_valid), 64'd0);
        cycles(1);
        check("chg_lat_e2", 64'(sum_valid), 64'd1);
        cycles(25);
        push(D22, 32'd6, 16'd1);
        pulse_flush();
        drain("drain_change", 20);

        // Backpressure: summary held stable while a new record arrives
        sum_ready = 1'b0;
        send(D33, 16'h0001, 16'h0005);
        cycles(25);
        pulse_flush();
        cycles(2);
        check("bp_valid", 64'(sum_valid), 64'd1);
        send(D44, 16'h0002, 16'h0002);
        for (int k = 0; k < 30; k++) begin
            check("bp_hold_valid", 64'(sum_valid), 64'd1);
            check("bp_hold_date", date_p(), D33);
            check("bp_hold_total", 64'(sum_total), 64'd5);
            cycles(1);
        end
        push(D33, 32'd5, 16'd1);
        sum_ready = 1'b1;
        cycles(30);
        push(D44, 32'd4, 16'd1);
        pulse_flush();
        drain("drain_bp", 20);
        check("ovf_before", 64'(overflow), 64'd0);

        // Overflow: six back-to-back records, one is dropped
        for (int k = 0; k < 6; k++) send(D55, 16'h0001, 16'h0003);
        check("ovf_set", 64'(overflow), 64'd1);
        cycles(110);
        push(D55, 32'd15, 16'd5);
        pulse_flush();
        drain("drain_ovf", 20);

        // Saturation at 32-bit accumulator width
        send(D66, 16'hFFFF, 16'hFFFF);
        send(D66, 16'hFFFF, 16'hFFFF);
        cycles(45);
        push(D66, 32'hFFFFFFFF, 16'd2);
        pulse_flush();
        drain("drain_sat", 20);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Reset five cycles into MUL discards everything
        send(D77, 16'h0003, 16'h0004);
        cycles(7);
        rst = 1'b1;
        #1;
        check("mrst_valid", 64'(sum_valid), 64'd0);
        check("mrst_date", date_p(), 64'd0);
        check("mrst_total", 64'(sum_total), 64'd0);
        check("mrst_count", 64'(sum_count), 64'd0);
        check("mrst_overflow", 64'(overflow), 64'd0);
        cycles(1);
        rst = 1'b0;
        cycles(1);
        pulse_flush();
        cycles(10);
        check("mrst_no_summary", 64'(sum_valid), 64'd0);

        // Reset while presenting a summary drops sum_valid asynchronously
        sum_ready = 1'b0;
        send(D88, 16'h0001, 16'h0001);
        cycles(25);
        pulse_flush();
        cycles(2);
        check("erst_valid_pre", 64'(sum_valid), 64'd1);
        check("erst_date_pre", date_p(), D88);
        rst = 1'b1;
        #1;
        check("erst_valid", 64'(sum_valid), 64'd0);
        cycles(1);
        rst = 1'b0;
        sum_ready = 1'b1;
        cycles(10);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trade_summary.md
# trade_summary

Downstream consumer of the record parser's output. Each parsed record (8-byte date, 2-byte price, 2-byte num) is buffered in a small FIFO. The block computes amount = price × num with a 16-cycle shift-add multiplier and accumulates amounts per contiguous date group. When the date changes or `flush` is pulsed, it emits one summary (date, total, count) over a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, 4: record FIFO entries (power of 2, ≥2).
- `TOTAL_W`, 40: accumulator width (≥32).
- `CNT_W`, 16: record-count width.

Ports:
- `clk`  in  1: single clock; all logic rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: one-cycle pulse; record on `in_date`/`in_price`/`in_num` valid this cycle.
- `in_date`  in  8×[7:0] (unpacked [8]): date bytes, index 0 first-received.
- `in_price`  in  2×[7:0]: price; value = {in_price[0], in_price[1]}.
- `in_num`  in  2×[7:0]: quantity; value = {in_num[0], in_num[1]}.
- `flush`  in  1: pulse; close the open group after buffered records drain.
- `sum_valid`  out  1: summary available.
- `sum_ready`  in  1: consumer accepts summary.
- `sum_date`  out  8×[7:0]: group date.
- `sum_total`  out  TOTAL_W: Σ price×num, unsigned, saturating.
- `sum_count`  out  CNT_W: records in group, saturating.
- `overflow`  out  1: sticky; a record was dropped because the FIFO was full.

## Operation
- Input: the block has no backpressure. On `in_valid`, the record is written to the FIFO.
  - If the FIFO is full, the record is dropped and `overflow` is set. It clears only on reset.
  - A pop and a write in the same cycle while full: the write succeeds.
- `flush` sets `flush_pending`. Further pulses while pending are absorbed.
- Internal state: `grp_open`, `grp_date`, `grp_total`, `grp_count`, held record `hold_*`, product register, 4-bit iteration counter.
- FSM:
  - IDLE:
    - FIFO non-empty → pop head into `hold_*`, go to CHECK.
    - Else if `flush_pending`: if `grp_open`, go to EMIT with `after_emit`=IDLE; otherwise clear `flush_pending` and stay in IDLE.
  - CHECK:
    - `grp_open` and `hold_date` ≠ `grp_date` (all 64 bits compared) → EMIT with `after_emit`=MUL.
    - Else → MUL. If `grp_open`=0, first open the group: `grp_date`←`hold_date`, total=0, count=0, `grp_open`=1.
  - MUL: 16 cycles of shift-add over the price bits (LSB first), giving a 32-bit product. Then go to ACC.
  - ACC:
    - `grp_total` += product, saturating at all-ones.
    - `grp_count` += 1, saturating.
    - Go to IDLE.
  - EMIT:
    - `sum_valid`=1. Outputs are driven from `grp_*` and stay stable until handshake.
    - On `sum_valid & sum_ready`:
      - `grp_open`=0.
      - If `after_emit`=MUL: open the group with `hold_date`, then go to MUL.
      - Else: clear `flush_pending` and go to IDLE.
- Flush ordering: a flush is serviced only when the FIFO is empty. Records written before the service point join the group being flushed.

## Timing
- Reset values:
  - FSM in IDLE; FIFO empty.
  - `sum_valid`=0, `sum_date`=0, `sum_total`=0, `sum_count`=0, `overflow`=0.
  - `grp_open`=0, `flush_pending`=0.
- Record latency, with `in_valid` sampled at edge E0 and the FSM in IDLE:
  - Popped at E1; CHECK at E2.
  - MUL from E3 to E18.
  - `grp_total`/`grp_count` updated at E19.
- Throughput: one record per 20 cycles, matching the minimum 20-byte parser frame. Faster bursts are absorbed by the FIFO.
- Date change:
  - `sum_valid` rises the cycle after CHECK.
  - After the handshake edge, `sum_valid` drops next cycle and MUL starts.
- Flush with an open group and an empty FIFO: `sum_valid` rises 2 cycles after the `flush` pulse.
- `sum_valid` never drops without a handshake. Outputs are held while `sum_ready`=0; the FIFO keeps accepting records.
- Reset mid-operation (including mid-MUL or in EMIT): all state is discarded immediately and `sum_valid` drops asynchronously.

## Test plan
- Single record: date 8×0x11, price {0x12,0x34}, num {0x00,0x10}, then flush → one summary: date 8×0x11, total 0x12340, count 1.
- Same date twice: records as above, then flush → total 0x24680, count 2. A new date 8×0x22 → first summary emitted at CHECK of the 0x22 record; a later flush emits the second group.
- Backpressure: hold `sum_ready`=0 for 30 cycles during EMIT while sending 1 record → `sum_valid`, `sum_date` and `sum_total` stay constant. After release, the new record is accumulated and not lost.
- Overflow: 6 `in_valid` pulses on consecutive cycles, depth 4 → `overflow`=1; exactly 5 records accumulated (1 popped early), count 5.
- Saturation: price 0xFFFF, num 0xFFFF, TOTAL_W=32 → after the 2nd record `sum_total`=0xFFFFFFFF.
- Reset during MUL: assert `rst` 5 cycles into MUL → all outputs 0. A following flush produces no summary.
